// File: rtl/histogram_cdf_path_pkg.sv
// Shared types and bin-packing helpers for the histogram datapath and its CDF stage.
package histogram_cdf_path_pkg;

  localparam int unsigned BIN_WIDTH     = 32;
  localparam int unsigned BINS_PER_WORD = 4;
  localparam int unsigned WORD_WIDTH    = BIN_WIDTH * BINS_PER_WORD;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StCapture,
    StWrite,
    StDone
  } cdf_state_e;

  // Offset 0 lives in the most significant slice of the word.
  function automatic logic [BIN_WIDTH-1:0] get_bin(input logic [WORD_WIDTH-1:0] word,
                                                   input int unsigned offset);
    return word[WORD_WIDTH - 1 - offset * BIN_WIDTH -: BIN_WIDTH];
  endfunction

  function automatic logic [WORD_WIDTH-1:0] put_bin(input logic [WORD_WIDTH-1:0] word,
                                                    input int unsigned offset,
                                                    input logic [BIN_WIDTH-1:0] value);
    logic [WORD_WIDTH-1:0] res;
    res = word;
    res[WORD_WIDTH - 1 - offset * BIN_WIDTH -: BIN_WIDTH] = value;
    return res;
  endfunction

endpackage

// File: rtl/histogram_cdf_path_add4.sv
// Combinational 4-lane prefix adder for one packed CDF word.
// HISTOGRAM_CDF_SATURATE_EN selects clamping adds instead of 32-bit wrap.
module histogram_cdf_add4
  import histogram_cdf_path_pkg::*;
(
  input  logic [BIN_WIDTH-1:0]  sum_i,
  input  logic [WORD_WIDTH-1:0] word_i,
  output logic [WORD_WIDTH-1:0] cdf_o,
  output logic [BIN_WIDTH-1:0]  sum_o
);

`ifdef HISTOGRAM_CDF_SATURATE_EN
  function automatic logic [BIN_WIDTH-1:0] lane_add(input logic [BIN_WIDTH-1:0] a,
                                                    input logic [BIN_WIDTH-1:0] b);
    logic [BIN_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[BIN_WIDTH] ? {BIN_WIDTH{1'b1}} : s[BIN_WIDTH-1:0];
  endfunction
`else
  function automatic logic [BIN_WIDTH-1:0] lane_add(input logic [BIN_WIDTH-1:0] a,
                                                    input logic [BIN_WIDTH-1:0] b);
    return a + b;
  endfunction
`endif

  logic [BIN_WIDTH-1:0] acc;

  always_comb begin
    acc   = sum_i;
    cdf_o = '0;
    for (int unsigned o = 0; o < BINS_PER_WORD; o++) begin
      acc   = lane_add(acc, get_bin(word_i, o));
      cdf_o = put_bin(cdf_o, o, acc);
    end
    sum_o = acc;
  end

endmodule

// File: rtl/histogram_cdf_path.sv
// Walks the scratch histogram memory and writes the running-sum CDF plus total count.
// Optional HISTOGRAM_CDF_SATURATE_EN (inside histogram_cdf_add4) clamps the sums.
module histogram_cdf_path
  import histogram_cdf_path_pkg::*;
#(
  parameter int unsigned NUM_WORDS     = 64,
  parameter logic [15:0] CDF_BASE_ADDR = 16'd0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [63:0]           bin_word_valid,
  input  logic [WORD_WIDTH-1:0] scratch_memory_rdata,
  output logic [15:0]           scratch_read_address,
  output logic                  cdf_write_enable,
  output logic [15:0]           cdf_write_address,
  output logic [WORD_WIDTH-1:0] cdf_wdata,
  output logic [BIN_WIDTH-1:0]  total_count,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned IdxW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_WORDS - 1);

  cdf_state_e            state_q, state_d;
  logic [IdxW-1:0]       word_idx_q, word_idx_d;
  logic [BIN_WIDTH-1:0]  sum_q, sum_d;
  logic [WORD_WIDTH-1:0] data_q, data_d;
  logic [15:0]           rd_addr_q, rd_addr_d;
  logic                  wr_en_q, wr_en_d;
  logic [15:0]           wr_addr_q, wr_addr_d;
  logic [WORD_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [BIN_WIDTH-1:0]  total_q, total_d;

  logic [WORD_WIDTH-1:0] cdf_word;
  logic [BIN_WIDTH-1:0]  cdf_sum;

  histogram_cdf_add4 u_add4 (
    .sum_i  (sum_q),
    .word_i (data_q),
    .cdf_o  (cdf_word),
    .sum_o  (cdf_sum)
  );

  always_comb begin
    state_d    = state_q;
    word_idx_d = word_idx_q;
    sum_d      = sum_q;
    data_d     = data_q;
    rd_addr_d  = rd_addr_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    total_d    = total_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StIssue;
          word_idx_d = '0;
          sum_d      = '0;
          total_d    = '0;
        end
      end
      StIssue: begin
        rd_addr_d = 16'(word_idx_q);
        state_d   = StWait;
      end
      StWait: state_d = StCapture;
      StCapture: begin
        // Unwritten scratch words read as X; force them to zero counts.
        data_d  = bin_word_valid[word_idx_q] ? scratch_memory_rdata : '0;
        state_d = StWrite;
      end
      StWrite: begin
        wr_data_d = cdf_word;
        wr_addr_d = CDF_BASE_ADDR + 16'(word_idx_q);
        wr_en_d   = 1'b1;
        sum_d     = cdf_sum;
        if (word_idx_q == LastIdx) begin
          state_d = StDone;
        end else begin
          word_idx_d = word_idx_q + 1'b1;
          state_d    = StIssue;
        end
      end
      StDone: begin
        total_d = sum_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      word_idx_q <= '0;
      sum_q      <= '0;
      data_q     <= '0;
      rd_addr_q  <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      total_q    <= '0;
    end else begin
      state_q    <= state_d;
      word_idx_q <= word_idx_d;
      sum_q      <= sum_d;
      data_q     <= data_d;
      rd_addr_q  <= rd_addr_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      total_q    <= total_d;
    end
  end

  assign scratch_read_address = rd_addr_q;
  assign cdf_write_enable     = wr_en_q;
  assign cdf_write_address    = wr_addr_q;
  assign cdf_wdata            = wr_data_q;
  assign total_count          = total_q;
  assign busy = (state_q == StIssue) || (state_q == StWait) ||
                (state_q == StCapture) || (state_q == StWrite);
  assign done = (state_q == StDone);

endmodule
